// File: rtl/tiny_acc_pkg.sv
// Shared constants for the tiny accumulator core: opcodes, FSM state codes
// and the word that fills IMEM after reset.
package tiny_acc_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SLL  = 4'h2;
  localparam logic [3:0] OP_JNZ  = 4'h3;
  localparam logic [3:0] OP_SRL  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LI   = 4'h9;
  localparam logic [3:0] OP_SLLI = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hB;
  localparam logic [3:0] OP_NOP  = 4'hC;
  localparam logic [3:0] OP_CLR  = 4'hD;
  localparam logic [3:0] OP_LA   = 4'hE;
  localparam logic [3:0] OP_SA   = 4'hF;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_HALTED = 2'b10;

  localparam logic [7:0] RESET_INSTR = 8'h0B;

  // Only the add/subtract family touches the carry flag.
  function automatic logic op_updates_carry(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/tiny_acc_alu.sv
// Combinational ALU: computes the next accumulator value, the carry and
// whether the opcode writes the accumulator at all.
module tiny_acc_alu
  import tiny_acc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]               i_op,
  input  logic [DATA_W-1:0]        i_acc,
  input  logic [DATA_W-1:0]        i_mem,
  input  logic signed [DATA_W-1:0] i_imm,
  output logic [DATA_W-1:0]        o_result,
  output logic                     o_carry,
  output logic                     o_acc_we
);

  logic [DATA_W:0] w_sum;

  always_comb begin
    w_sum    = '0;
    o_result = i_acc;
    o_carry  = 1'b0;
    o_acc_we = 1'b1;
    case (i_op)
      OP_ADD: begin
        w_sum    = {1'b0, i_acc} + {1'b0, i_mem};
        o_result = w_sum[DATA_W-1:0];
        o_carry  = w_sum[DATA_W];
      end
      // The extra top bit of the difference is the borrow; carry is its inverse.
      OP_SUB: begin
        w_sum    = {1'b0, i_acc} - {1'b0, i_mem};
        o_result = w_sum[DATA_W-1:0];
        o_carry  = ~w_sum[DATA_W];
      end
      OP_SLL:  o_result = i_acc << i_mem[2:0];
      OP_SRL:  o_result = i_acc >> i_mem[2:0];
      OP_NAND: o_result = ~(i_acc & i_mem);
      OP_XOR:  o_result = i_acc ^ i_mem;
      OP_ADDI: begin
        w_sum    = {1'b0, i_acc} + {1'b0, i_imm};
        o_result = w_sum[DATA_W-1:0];
        o_carry  = w_sum[DATA_W];
      end
      OP_LI:   o_result = i_imm;
      OP_SLLI: o_result = i_acc << i_imm[2:0];
      OP_CLR:  o_result = '0;
      OP_LA:   o_result = i_mem;
      default: o_acc_we = 1'b0;
    endcase
  end

endmodule

// File: rtl/tiny_acc_core.sv
// Single-cycle accumulator core: control FSM, pc, private IMEM/DMEM,
// Z/C flags, handshaked program-load port and debug DMEM read port.
module tiny_acc_core
  import tiny_acc_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
  input  logic [7:0]                    load_data,
  input  logic                          start,
  input  logic                          step,
  input  logic                          halt_req,
  input  logic [$clog2(DMEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_W-1:0]             dbg_data,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  output logic [DATA_W-1:0]             acc,
  output logic                          flag_z,
  output logic                          flag_c,
  output logic [1:0]                    state
);

  localparam int PC_W = $clog2(IMEM_DEPTH);

  logic [7:0]        r_imem [IMEM_DEPTH];
  logic [DATA_W-1:0] r_dmem [DMEM_DEPTH];
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_acc;
  logic              r_z;
  logic              r_c;
  logic [1:0]        r_state;

  logic [7:0]               w_instr;
  logic [3:0]               w_op;
  logic [3:0]               w_opnd;
  logic [DATA_W-1:0]        w_mem;
  logic signed [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0]        w_result;
  logic                     w_carry;
  logic                     w_acc_we;
  logic                     w_is_branch;
  logic                     w_taken;
  logic                     w_last;
  logic                     w_start;
  logic                     w_exec;

  assign w_instr = r_imem[r_pc];
  assign w_op    = w_instr[3:0];
  assign w_opnd  = w_instr[7:4];
  assign w_imm   = DATA_W'($signed(w_opnd));

  // Out-of-range DMEM addresses simply match no entry and read as zero.
  always_comb begin
    w_mem    = '0;
    dbg_data = '0;
    for (int i = 0; i < DMEM_DEPTH; i++) begin
      if (int'(w_opnd) == i)   w_mem    = r_dmem[i];
      if (int'(dbg_addr) == i) dbg_data = r_dmem[i];
    end
  end

  assign w_is_branch = (w_op == OP_JNZ) || (w_op == OP_JZ);
  assign w_taken     = ((w_op == OP_JNZ) && (r_acc != '0)) ||
                       ((w_op == OP_JZ)  && (r_acc == '0));
  assign w_last      = (r_pc == PC_W'(IMEM_DEPTH - 1));
  assign w_start     = start && (r_state != ST_RUN);
  assign w_exec      = ((r_state == ST_RUN) && !halt_req) ||
                       ((r_state == ST_IDLE) && step && !start);

  tiny_acc_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op     (w_op),
    .i_acc    (r_acc),
    .i_mem    (w_mem),
    .i_imm    (w_imm),
    .o_result (w_result),
    .o_carry  (w_carry),
    .o_acc_we (w_acc_we)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_acc   <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      for (int i = 0; i < IMEM_DEPTH; i++) r_imem[i] <= RESET_INSTR;
      for (int i = 0; i < DMEM_DEPTH; i++) r_dmem[i] <= '0;
    end else begin
      if (load_valid && load_ready) r_imem[load_addr] <= load_data;
      if (w_start) begin
        r_state <= ST_RUN;
        r_pc    <= '0;
        r_acc   <= '0;
        r_z     <= 1'b0;
        r_c     <= 1'b0;
      end else if ((r_state == ST_RUN) && halt_req) begin
        r_state <= ST_HALTED;
      end else if (w_exec) begin
        if (w_acc_we) begin
          r_acc <= w_result;
          r_z   <= (w_result == '0);
        end
        if (op_updates_carry(w_op)) r_c <= w_carry;
        for (int i = 0; i < DMEM_DEPTH; i++)
          if ((w_op == OP_SA) && (int'(w_opnd) == i)) r_dmem[i] <= r_acc;
        // HALT and falling off the end in RUN both leave pc on the last executed word.
        if (w_op == OP_HALT)
          r_state <= ST_HALTED;
        else if (w_taken)
          r_pc <= w_opnd[PC_W-1:0];
        else if ((r_state == ST_RUN) && !w_is_branch && w_last)
          r_state <= ST_HALTED;
        else
          r_pc <= r_pc + PC_W'(1);
      end
    end
  end

  assign load_ready = (r_state != ST_RUN);
  assign pc         = r_pc;
  assign acc        = r_acc;
  assign flag_z     = r_z;
  assign flag_c     = r_c;
  assign state      = r_state;

endmodule

// File: tb/tb_tiny_acc_core.sv
// Testbench for tiny_acc_core: directed programs plus randomized lockstep
// comparison against an instruction-level reference model.
module tb_tiny_acc_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic       load_valid = 1'b0;
  logic [3:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic       start = 1'b0;
  logic       step = 1'b0;
  logic       halt_req = 1'b0;
  logic [3:0] a_dbg_addr = '0;
  logic [2:0] b_dbg_addr = '0;

  logic        a_load_ready, a_z, a_c;
  logic [7:0]  a_dbg_data, a_acc;
  logic [3:0]  a_pc;
  logic [1:0]  a_state;
  logic        b_load_ready, b_z, b_c;
  logic [15:0] b_dbg_data, b_acc;
  logic [3:0]  b_pc;
  logic [1:0]  b_state;

  int n_tests = 0;
  int n_fail  = 0;

  tiny_acc_core #(.DATA_W(8), .IMEM_DEPTH(16), .DMEM_DEPTH(16)) u_dut (
    .clk(clk), .rst(rst_a), .load_valid(load_valid), .load_ready(a_load_ready),
    .load_addr(load_addr), .load_data(load_data), .start(start), .step(step),
    .halt_req(halt_req), .dbg_addr(a_dbg_addr), .dbg_data(a_dbg_data), .pc(a_pc),
    .acc(a_acc), .flag_z(a_z), .flag_c(a_c), .state(a_state)
  );

  tiny_acc_core #(.DATA_W(16), .IMEM_DEPTH(16), .DMEM_DEPTH(8)) u_dut16 (
    .clk(clk), .rst(rst_b), .load_valid(load_valid), .load_ready(b_load_ready),
    .load_addr(load_addr), .load_data(load_data), .start(start), .step(step),
    .halt_req(halt_req), .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data), .pc(b_pc),
    .acc(b_acc), .flag_z(b_z), .flag_c(b_c), .state(b_state)
  );

  // Reference model of the 8-bit instance, advanced once per clock edge.
  localparam int     M_IMD = 16;
  localparam int     M_DMD = 16;
  localparam longint M_MOD = 256;

  logic [7:0] m_imem [16];
  longint     m_dmem [16];
  longint     m_acc;
  int         m_pc;
  int         m_st;
  bit         m_z, m_c;

  task automatic model_edge();
    logic [7:0] ins;
    int op, od;
    longint mv, imm, s;
    bit wr, taken;
    if (rst_a) begin
      m_st = 0; m_pc = 0; m_acc = 0; m_z = 0; m_c = 0;
      for (int i = 0; i < 16; i++) begin m_imem[i] = 8'h0B; m_dmem[i] = 0; end
      return;
    end
    ins = m_imem[m_pc];
    if (load_valid && m_st != 1) m_imem[load_addr] = load_data;
    if (start && m_st != 1) begin
      m_st = 1; m_pc = 0; m_acc = 0; m_z = 0; m_c = 0;
      return;
    end
    if (m_st == 1 && halt_req) begin m_st = 2; return; end
    if (!(m_st == 1 || (m_st == 0 && step))) return;
    op  = int'(ins[3:0]);
    od  = int'(ins[7:4]);
    mv  = (od < M_DMD) ? m_dmem[od] : 0;
    imm = (od >= 8) ? M_MOD - 16 + od : od;
    taken = (op == 3 && m_acc != 0) || (op == 5 && m_acc == 0);
    wr = 1;
    case (op)
      0:  begin s = m_acc + mv;  m_c = (s >= M_MOD); m_acc = s % M_MOD; end
      1:  begin m_c = (m_acc >= mv); m_acc = (m_acc - mv + M_MOD) % M_MOD; end
      2:  m_acc = (m_acc * (longint'(1) << (mv % 8))) % M_MOD;
      4:  m_acc = m_acc / (longint'(1) << (mv % 8));
      6:  m_acc = (M_MOD - 1) - (m_acc & mv);
      7:  m_acc = m_acc ^ mv;
      8:  begin s = m_acc + imm; m_c = (s >= M_MOD); m_acc = s % M_MOD; end
      9:  m_acc = imm;
      10: m_acc = (m_acc * (longint'(1) << (od % 8))) % M_MOD;
      13: m_acc = 0;
      14: m_acc = mv;
      default: wr = 0;
    endcase
    if (op == 15 && od < M_DMD) m_dmem[od] = m_acc;
    if (wr) m_z = (m_acc == 0);
    if (op == 11) m_st = 2;
    else if (taken) m_pc = od % M_IMD;
    else if (m_st == 1 && op != 3 && op != 5 && m_pc == M_IMD - 1) m_st = 2;
    else m_pc = (m_pc + 1) % M_IMD;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    load_valid = 0; start = 0; step = 0; halt_req = 0;
    rst_a = 1;
    tick();
    rst_a = 0;
  endtask

  task automatic load_word(input logic [3:0] addr, input logic [7:0] data);
    load_valid = 1; load_addr = addr; load_data = data;
    tick();
    load_valid = 0;
  endtask

  task automatic run_to_halt(output int cyc, input int budget);
    start = 1;
    tick();
    start = 0;
    cyc = 0;
    while (a_state != 2'b10 && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset_a();
    a_dbg_addr = 4'd3; #1;
    if (a_pc !== 4'd0)      begin n_fail++; $display("FAIL reset_pc: got %0h want 0", a_pc); end
    n_tests++;
    if (a_acc !== 8'd0)     begin n_fail++; $display("FAIL reset_acc: got %0h want 0", a_acc); end
    n_tests++;
    if ({a_z, a_c} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {a_z, a_c}); end
    n_tests++;
    if (a_state !== 2'b00)  begin n_fail++; $display("FAIL reset_state: got %0h want 0", a_state); end
    n_tests++;
    if (a_load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", a_load_ready); end
    n_tests++;
    if (a_dbg_data !== 8'd0) begin n_fail++; $display("FAIL reset_dmem: got %0h want 0", a_dbg_data); end
    n_tests++;
    step = 1; tick(); step = 0;
    if (a_state !== 2'b10 || a_pc !== 4'd0) begin
      n_fail++; $display("FAIL reset_imem_halt: got state %0h pc %0h want 2/0", a_state, a_pc);
    end
    n_tests++;
  endtask

  task automatic test_basic();
    int cyc;
    reset_a();
    load_word(4'd0, 8'h59); load_word(4'd1, 8'h0F); load_word(4'd2, 8'h0B);
    run_to_halt(cyc, 40);
    a_dbg_addr = 4'd0; #1;
    if (cyc !== 3)          begin n_fail++; $display("FAIL basic_cycles: got %0d want 3", cyc); end
    n_tests++;
    if (a_acc !== 8'h05)    begin n_fail++; $display("FAIL basic_acc: got %0h want 05", a_acc); end
    n_tests++;
    if (a_dbg_data !== 8'h05) begin n_fail++; $display("FAIL basic_dmem0: got %0h want 05", a_dbg_data); end
    n_tests++;
    if (a_pc !== 4'd2)      begin n_fail++; $display("FAIL basic_pc: got %0h want 2", a_pc); end
    n_tests++;
  endtask

  task automatic test_countdown();
    int cyc;
    reset_a();
    load_word(4'd0, 8'h39); load_word(4'd1, 8'hF8);
    load_word(4'd2, 8'h13); load_word(4'd3, 8'h0B);
    run_to_halt(cyc, 60);
    if (cyc !== 8)          begin n_fail++; $display("FAIL countdown_cycles: got %0d want 8", cyc); end
    n_tests++;
    if (a_acc !== 8'h00 || a_z !== 1'b1) begin
      n_fail++; $display("FAIL countdown_acc_z: got %0h/%b want 00/1", a_acc, a_z);
    end
    n_tests++;
  endtask

  task automatic test_carry();
    int cyc;
    reset_a();
    load_word(4'd0, 8'hF9); load_word(4'd1, 8'h18); load_word(4'd2, 8'h0B);
    run_to_halt(cyc, 40);
    if (a_acc !== 8'h00)    begin n_fail++; $display("FAIL carry_acc: got %0h want 00", a_acc); end
    n_tests++;
    if ({a_c, a_z} !== 2'b11) begin n_fail++; $display("FAIL carry_cz: got %b want 11", {a_c, a_z}); end
    n_tests++;
  endtask

  task automatic test_step();
    reset_a();
    load_word(4'd0, 8'h59); load_word(4'd1, 8'h0F);
    a_dbg_addr = 4'd0;
    step = 1; tick(); step = 0;
    if (a_pc !== 4'd1 || a_acc !== 8'h05) begin
      n_fail++; $display("FAIL step1_pc_acc: got %0h/%0h want 1/05", a_pc, a_acc);
    end
    n_tests++;
    if (a_dbg_data !== 8'h00 || a_state !== 2'b00) begin
      n_fail++; $display("FAIL step1_dmem_state: got %0h/%0h want 00/0", a_dbg_data, a_state);
    end
    n_tests++;
    step = 1; tick(); step = 0;
    if (a_dbg_data !== 8'h05 || a_pc !== 4'd2) begin
      n_fail++; $display("FAIL step2_dmem_pc: got %0h/%0h want 05/2", a_dbg_data, a_pc);
    end
    n_tests++;
  endtask

  task automatic test_run_control();
    logic [3:0] p0;
    reset_a();
    load_word(4'd0, 8'h0C); load_word(4'd1, 8'h05);
    start = 1; tick(); start = 0;
    repeat (5) tick();
    if (a_state !== 2'b01 || a_load_ready !== 1'b0) begin
      n_fail++; $display("FAIL run_state_ready: got %0h/%b want 1/0", a_state, a_load_ready);
    end
    n_tests++;
    load_word(4'd0, 8'h0B);
    p0 = a_pc;
    halt_req = 1; tick(); halt_req = 0;
    if (a_state !== 2'b10 || a_pc !== p0) begin
      n_fail++; $display("FAIL halt_req: got state %0h pc %0h want 2/%0h", a_state, a_pc, p0);
    end
    n_tests++;
    start = 1; tick(); start = 0;
    repeat (4) tick();
    if (a_state !== 2'b01) begin n_fail++; $display("FAIL run_imem_kept: got state %0h want 1", a_state); end
    n_tests++;
    reset_a();
    a_dbg_addr = 4'd0; #1;
    if ({a_state, a_pc, a_acc, a_z, a_c, a_load_ready} !== {2'b00, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL midrun_reset: got st %0h pc %0h acc %0h z %b c %b rdy %b want 0/0/0/0/0/1",
                         a_state, a_pc, a_acc, a_z, a_c, a_load_ready);
    end
    n_tests++;
    step = 1; tick(); step = 0;
    if (a_state !== 2'b10) begin n_fail++; $display("FAIL midrun_imem_reset: got state %0h want 2", a_state); end
    n_tests++;
  endtask

  task automatic test_simultaneous();
    int cyc;
    reset_a();
    load_word(4'd0, 8'h39);
    start = 1; step = 1; tick(); start = 0; step = 0;
    if (a_state !== 2'b01 || a_acc !== 8'h00) begin
      n_fail++; $display("FAIL start_over_step: got %0h/%0h want 1/00", a_state, a_acc);
    end
    n_tests++;
    reset_a();
    load_valid = 1; load_addr = 4'd0; load_data = 8'h59; start = 1;
    tick();
    load_valid = 0; start = 0; cyc = 0;
    while (a_state != 2'b10 && cyc < 20) begin tick(); cyc++; end
    if (cyc !== 2 || a_acc !== 8'h05) begin
      n_fail++; $display("FAIL load_with_start: got cyc %0d acc %0h want 2/05", cyc, a_acc);
    end
    n_tests++;
  endtask

  task automatic test_random();
    reset_a();
    for (int i = 0; i < 16; i++) load_word(4'(i), 8'($urandom));
    for (int c = 0; c < 600; c++) begin
      start      = ($urandom_range(15) == 0);
      step       = ($urandom_range(2) == 0);
      halt_req   = ($urandom_range(24) == 0);
      load_valid = ($urandom_range(7) == 0);
      load_addr  = 4'($urandom);
      load_data  = 8'($urandom);
      rst_a      = ($urandom_range(299) == 0);
      a_dbg_addr = 4'($urandom);
      tick();
      if (a_pc !== 4'(m_pc))   begin n_fail++; $display("FAIL rand_pc c%0d: got %0h want %0h", c, a_pc, m_pc); end
      n_tests++;
      if (a_acc !== 8'(m_acc)) begin n_fail++; $display("FAIL rand_acc c%0d: got %0h want %0h", c, a_acc, m_acc); end
      n_tests++;
      if ({a_z, a_c} !== {m_z, m_c}) begin
        n_fail++; $display("FAIL rand_flags c%0d: got %b want %b", c, {a_z, a_c}, {m_z, m_c});
      end
      n_tests++;
      if (a_state !== 2'(m_st)) begin n_fail++; $display("FAIL rand_state c%0d: got %0h want %0h", c, a_state, m_st); end
      n_tests++;
      if (a_load_ready !== (m_st != 1)) begin
        n_fail++; $display("FAIL rand_ready c%0d: got %b want %b", c, a_load_ready, m_st != 1);
      end
      n_tests++;
      if (a_dbg_data !== 8'(m_dmem[a_dbg_addr])) begin
        n_fail++; $display("FAIL rand_dbg c%0d: got %0h want %0h", c, a_dbg_data, m_dmem[a_dbg_addr]);
      end
      n_tests++;
    end
    start = 0; step = 0; halt_req = 0; load_valid = 0; rst_a = 0;
  endtask

  task automatic test_param_sweep();
    int cyc;
    rst_a = 1; rst_b = 1;
    tick();
    rst_b = 0;
    load_word(4'd0, 8'hF9); load_word(4'd1, 8'h9F); load_word(4'd2, 8'h0F);
    load_word(4'd3, 8'h9E); load_word(4'd4, 8'h0B);
    step = 1; tick(); step = 0;
    if (b_acc !== 16'hFFFF || b_pc !== 4'd1) begin
      n_fail++; $display("FAIL w16_li_sext: got %0h/%0h want ffff/1", b_acc, b_pc);
    end
    n_tests++;
    start = 1; tick(); start = 0;
    cyc = 0;
    while (b_state != 2'b10 && cyc < 20) begin tick(); cyc++; end
    if (cyc !== 5) begin n_fail++; $display("FAIL w16_cycles: got %0d want 5", cyc); end
    n_tests++;
    if (b_acc !== 16'h0000 || b_z !== 1'b1) begin
      n_fail++; $display("FAIL w16_la_oob: got %0h/%b want 0/1", b_acc, b_z);
    end
    n_tests++;
    b_dbg_addr = 3'd0; #1;
    if (b_dbg_data !== 16'hFFFF) begin n_fail++; $display("FAIL w16_sa0: got %0h want ffff", b_dbg_data); end
    n_tests++;
    b_dbg_addr = 3'd1; #1;
    if (b_dbg_data !== 16'h0000) begin n_fail++; $display("FAIL w16_sa_oob_dropped: got %0h want 0", b_dbg_data); end
    n_tests++;
    rst_b = 1; rst_a = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick();
    tick();
    test_reset();
    test_basic();
    test_countdown();
    test_carry();
    test_step();
    test_run_control();
    test_simultaneous();
    test_random();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
